// File: rtl/display_pkg.sv
// Shared constants and types for the seven-segment display capture path.
package display_pkg;

  localparam int ONES      = 0;
  localparam int TENS      = 1;
  localparam int HUNDREDS  = 2;
  localparam int THOUSANDS = 3;

  // Active-high gfedcba patterns
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam logic [3:0] BLANK_SELECT = 4'b1111;

  typedef enum logic {SCAN, EVAL} state_t;

  // One BCD nibble per digit position, indexed by ONES..THOUSANDS
  typedef logic [3:0][3:0] frame_t;

  // Position of the lowest low bit of an active-low select
  function automatic logic [1:0] low_index(input logic [3:0] sel_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!sel_n[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational seven-segment (active-high gfedcba) to BCD decoder.
module seg7_to_bcd
  import display_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       valid
);

  always_comb begin
    value = 4'd0;
    valid = 1'b1;
    case (seg)
      SEG_0:   value = 4'd0;
      SEG_1:   value = 4'd1;
      SEG_2:   value = 4'd2;
      SEG_3:   value = 4'd3;
      SEG_4:   value = 4'd4;
      SEG_5:   value = 4'd5;
      SEG_6:   value = 4'd6;
      SEG_7:   value = 4'd7;
      SEG_8:   value = 4'd8;
      SEG_9:   value = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/display_scan_decoder.sv
// Captures a scanned 4-digit seven-segment display and publishes BCD digits
// once MATCH_FRAMES identical complete frames have been seen.
module display_scan_decoder
  import display_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 4,
  parameter int MATCH_FRAMES   = 2,
  parameter int TIMEOUT_CYCLES = 65535
)(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] controlIn,
  input  logic [7:0] segIn,
  output logic [3:0] onesOut,
  output logic [3:0] tensOut,
  output logic [3:0] hundredsOut,
  output logic [3:0] thousandsOut,
  output logic       updatePulse,
  output logic       lockedOut,
  output logic       errorOut,
  output logic       lostOut
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int MW = $clog2(MATCH_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_HIT = SW'(SETTLE_CYCLES - 1);
  localparam logic [MW-1:0] MATCH_MAX  = MW'(MATCH_FRAMES);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);

  // Synchronizer, idles at all-ones (nothing selected, all segments off)
  logic [SYNC_STAGES-1:0][11:0] sync_q;
  logic [11:0] bus, bus_q;

  always_ff @(posedge clock or posedge reset)
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], {controlIn, segIn}};

  assign bus = sync_q[SYNC_STAGES-1];

  // Settle filter: one acceptance per dwell, when the run length hits SETTLE
  logic [SW-1:0] settle_cnt;
  logic          stable, accept;

  assign stable = (bus == bus_q);
  assign accept = stable && (settle_cnt == SETTLE_HIT);

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      bus_q      <= '1;
      settle_cnt <= '0;
    end else begin
      bus_q <= bus;
      if (!stable)                      settle_cnt <= '0;
      else if (settle_cnt != SETTLE_MAX) settle_cnt <= settle_cnt + 1'b1;
    end

  // A sample landing in EVAL (only possible with SETTLE_CYCLES = 1) waits a cycle
  state_t      state, state_nx;
  logic        pend_vld, proc_vld;
  logic [11:0] pend_bus, proc_bus;

  assign proc_vld = pend_vld || (accept && state == SCAN);
  assign proc_bus = pend_vld ? pend_bus : bus;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      pend_vld <= 1'b0;
      pend_bus <= '1;
    end else begin
      pend_vld <= accept && (state == EVAL);
      if (accept && state == EVAL) pend_bus <= bus;
    end

  // Sample decode
  logic [3:0] sel;
  logic [6:0] seg_ah;
  logic [3:0] dec_val;
  logic       dec_ok, multi, smp_ok, smp_err, dp_unused;
  logic [1:0] idx;
  logic [3:0] smp_bit;

  assign sel       = ~proc_bus[11:8];
  assign seg_ah    = ~proc_bus[6:0];
  assign dp_unused = proc_bus[7];
  assign multi     = (sel & (sel - 4'd1)) != 4'd0;
  assign idx       = low_index(proc_bus[11:8]);
  assign smp_bit   = 4'b0001 << idx;

  seg7_to_bcd u_dec (
    .seg   (seg_ah),
    .value (dec_val),
    .valid (dec_ok)
  );

  always_comb begin
    smp_ok  = 1'b0;
    smp_err = 1'b0;
    if (proc_vld && proc_bus[11:8] != BLANK_SELECT) begin
      if (!multi && dec_ok) smp_ok  = 1'b1;
      else                  smp_err = 1'b1;
    end
  end

  // Frame FSM
  frame_t          frame_buf, last_frame, pub;
  logic [3:0]      seen_mask;
  logic [MW-1:0]   match_cnt, match_nx;
  logic [TW-1:0]   tmo_cnt, tmo_nx;
  logic            same, publish;

  always_ff @(posedge clock or posedge reset)
    if (reset) state <= SCAN;
    else       state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      SCAN:    if (smp_ok && ((seen_mask | smp_bit) == 4'hF)) state_nx = EVAL;
      EVAL:    state_nx = SCAN;
      default: state_nx = SCAN;
    endcase
  end

  assign same     = (frame_buf == last_frame);
  assign match_nx = !same ? MW'(1) :
                    (match_cnt == MATCH_MAX) ? match_cnt : match_cnt + 1'b1;
  // A repeat of an already-locked value that is on the outputs is silent
  assign publish  = (match_nx == MATCH_MAX) &&
                    (!(same && lockedOut) || frame_buf != pub);
  assign tmo_nx   = (state == EVAL) ? '0 :
                    (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + 1'b1;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      frame_buf   <= '0;
      last_frame  <= '0;
      pub         <= '0;
      seen_mask   <= '0;
      match_cnt   <= '0;
      tmo_cnt     <= '0;
      updatePulse <= 1'b0;
      lockedOut   <= 1'b0;
      errorOut    <= 1'b0;
      lostOut     <= 1'b0;
    end else begin
      updatePulse <= 1'b0;
      errorOut    <= 1'b0;
      tmo_cnt     <= tmo_nx;
      if (tmo_nx == TMO_MAX) begin
        lostOut   <= 1'b1;
        lockedOut <= 1'b0;
      end
      if (state == EVAL) begin
        seen_mask  <= '0;
        last_frame <= frame_buf;
        match_cnt  <= match_nx;
        lostOut    <= 1'b0;
        if (!same) lockedOut <= 1'b0;
        if (publish) begin
          pub         <= frame_buf;
          updatePulse <= 1'b1;
          lockedOut   <= 1'b1;
        end
      end else if (smp_ok) begin
        frame_buf[idx] <= dec_val;
        seen_mask[idx] <= 1'b1;
      end else if (smp_err) begin
        errorOut  <= 1'b1;
        seen_mask <= '0;
        match_cnt <= '0;
        lockedOut <= 1'b0;
      end
    end

  assign onesOut      = pub[ONES];
  assign tensOut      = pub[TENS];
  assign hundredsOut  = pub[HUNDREDS];
  assign thousandsOut = pub[THOUSANDS];

endmodule

// File: tb/tb_display_scan_decoder.sv
// Randomized bench for display_scan_decoder against a frame-level reference model.
module tb_display_scan_decoder;

  localparam int SYNC   = 2;
  localparam int SETTLE = 4;
  localparam int MATCH  = 2;
  localparam int TMO    = 64;
  localparam int HMAX   = 16384;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] controlIn = 4'hF;
  logic [7:0] segIn = 8'hFF;
  logic [3:0] onesOut, tensOut, hundredsOut, thousandsOut;
  logic       updatePulse, lockedOut, errorOut, lostOut;

  always #5 clock = ~clock;

  display_scan_decoder #(
    .SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE),
    .MATCH_FRAMES(MATCH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset), .controlIn(controlIn), .segIn(segIn),
    .onesOut(onesOut), .tensOut(tensOut), .hundredsOut(hundredsOut),
    .thousandsOut(thousandsOut), .updatePulse(updatePulse),
    .lockedOut(lockedOut), .errorOut(errorOut), .lostOut(lostOut)
  );

  int tests = 0, fails = 0;
  int cyc = 0, base = 0;
  int upd_seen = 0, err_seen = 0;
  bit started = 0;
  logic [11:0] hist [HMAX];

  // Reference model state, valid for the current cycle
  logic [15:0] m_frame, m_last, m_outs;
  logic [3:0]  m_mask;
  int          m_match, m_tcnt;
  bit          m_locked, m_lost, m_upd, m_err, m_eval;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F; 4'd1: return 7'h06; 4'd2: return 7'h5B;
      4'd3: return 7'h4F; 4'd4: return 7'h66; 4'd5: return 7'h6D;
      4'd6: return 7'h7D; 4'd7: return 7'h07; 4'd8: return 7'h7F;
      default: return 7'h6F;
    endcase
  endfunction

  function automatic int seg_value(input logic [6:0] s);
    for (int d = 0; d < 10; d++) if (seg_code(4'(d)) == s) return d;
    return -1;
  endfunction

  // Synced bus as seen by the design in cycle k (idle before reset release)
  function automatic logic [11:0] bus_at(input int k);
    if (k - SYNC < base) return 12'hFFF;
    return hist[k - SYNC];
  endfunction

  // Accepted in cycle k: bus has held its value for exactly SETTLE cycles
  function automatic bit accepted(input int k);
    for (int i = 1; i <= SETTLE; i++) if (bus_at(k - i) != bus_at(k)) return 0;
    return bus_at(k - SETTLE - 1) != bus_at(k);
  endfunction

  task automatic model_reset();
    m_frame = 0; m_last = 0; m_outs = 0; m_mask = 0;
    m_match = 0; m_tcnt = 0;
    m_locked = 0; m_lost = 0; m_upd = 0; m_err = 0; m_eval = 0;
  endtask

  task automatic model_step(input int k);
    logic [11:0] b;
    logic [3:0]  sel;
    int          d, nm, ix;
    bit          same;
    m_upd = 0;
    m_err = 0;
    if (m_eval) begin
      same = (m_frame == m_last);
      nm = same ? ((m_match + 1 > MATCH) ? MATCH : m_match + 1) : 1;
      if (!same) m_locked = 0;
      m_last  = m_frame;
      m_match = nm;
      if (nm == MATCH && (!m_locked || m_frame != m_outs)) begin
        m_outs = m_frame; m_upd = 1; m_locked = 1;
      end
      m_mask = 0; m_tcnt = 0; m_lost = 0; m_eval = 0;
    end else begin
      if (m_tcnt < TMO) m_tcnt++;
      if (m_tcnt == TMO) begin m_lost = 1; m_locked = 0; end
    end
    if (accepted(k - 1)) begin
      b   = bus_at(k - 1);
      sel = ~b[11:8];
      if (sel != 4'd0) begin
        d = seg_value(~b[6:0]);
        if ($countones(sel) == 1 && d >= 0) begin
          ix = 0;
          for (int i = 0; i < 4; i++) if (sel[i]) ix = i;
          m_frame[ix*4 +: 4] = 4'(d);
          m_mask[ix] = 1'b1;
          if (m_mask == 4'hF) m_eval = 1;
        end else begin
          m_err = 1; m_mask = 0; m_match = 0; m_locked = 0;
        end
      end
    end
  endtask

  // Advance n cycles holding the given pin values from just after each edge
  task automatic drive(input logic [3:0] c, input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      cyc++;
      if (cyc >= HMAX) begin
        $display("FAIL cycle_budget: got %0d expected below %0d", cyc, HMAX);
        $fatal(1, "cycle budget exhausted");
      end
      if (!reset) model_step(cyc);
      controlIn = c;
      segIn     = s;
      hist[cyc] = {c, s};
    end
  endtask

  task automatic scan_frame(input logic [15:0] v, input int dwell, input int gap);
    logic [3:0] c;
    for (int i = 0; i < 4; i++) begin
      c = ~(4'b0001 << i);
      drive(c, {1'($urandom_range(0, 1)), ~seg_code(v[i*4 +: 4])}, dwell);
      drive(4'hF, 8'hFF, gap);
    end
  endtask

  task automatic check_outs(input string name, input logic [15:0] exp);
    check(name, {thousandsOut, hundredsOut, tensOut, onesOut}, exp);
  endtask

  always @(negedge clock) begin
    if (started) begin
      check("cyc_outs", {thousandsOut, hundredsOut, tensOut, onesOut}, m_outs);
      check("cyc_update", updatePulse, m_upd);
      check("cyc_locked", lockedOut, m_locked);
      check("cyc_error", errorOut, m_err);
      check("cyc_lost", lostOut, m_lost);
      if (updatePulse) upd_seen++;
      if (errorOut)    err_seen++;
    end
  end

  initial begin
    logic [15:0] cur;
    logic [3:0]  c;
    logic [7:0]  s;
    int          r, u0;

    model_reset();
    for (int i = 0; i < HMAX; i++) hist[i] = 12'hFFF;
    #1 reset = 1'b1;
    #1;
    check_outs("reset_outs", 16'h0000);
    check("reset_flags", {updatePulse, lockedOut, errorOut, lostOut}, 4'b0000);
    started = 1;
    drive(4'hF, 8'hFF, 3);
    reset = 1'b0;
    base  = cyc;
    drive(4'hF, 8'hFF, 4);

    // Lock on 1234: publish at frame 2, silent on frame 3
    scan_frame(16'h1234, 8, 2);
    check("no_pub_frame1", upd_seen, 0);
    scan_frame(16'h1234, 8, 2);
    check("pub_frame2", upd_seen, 1);
    check_outs("outs_1234", 16'h1234);
    check("locked_1234", lockedOut, 1);
    scan_frame(16'h1234, 8, 2);
    check("silent_frame3", upd_seen, 1);

    // Change to 1235: unlock first, republish one frame later
    scan_frame(16'h1235, 8, 2);
    check("unlock_1235", lockedOut, 0);
    check_outs("hold_1234", 16'h1234);
    scan_frame(16'h1235, 8, 2);
    check("pub_1235", upd_seen, 2);
    check_outs("outs_1235", 16'h1235);

    // Invalid segment code during tens dwell aborts the frame
    drive(4'b1110, {1'b1, ~seg_code(4'd5)}, 8); drive(4'hF, 8'hFF, 2);
    drive(4'b1101, 8'h49, 8);                   drive(4'hF, 8'hFF, 2);
    drive(4'b1011, {1'b1, ~seg_code(4'd2)}, 8); drive(4'hF, 8'hFF, 2);
    drive(4'b0111, {1'b1, ~seg_code(4'd1)}, 8); drive(4'hF, 8'hFF, 2);
    check("bad_seg_err", err_seen, 1);
    check("bad_seg_unlock", lockedOut, 0);
    scan_frame(16'h1235, 8, 2);
    scan_frame(16'h1235, 8, 2);
    check("republish", upd_seen, 3);

    // Multi-select errors, long blank does not, and times out
    drive(4'b1100, {1'b1, ~seg_code(4'd8)}, 10);
    check("multi_sel_err", err_seen, 2);
    drive(4'hF, 8'hFF, 100);
    check("blank_no_err", err_seen, 2);
    check("lost_set", lostOut, 1);
    check("lost_unlock", lockedOut, 0);
    check_outs("lost_hold", 16'h1235);
    scan_frame(16'h1235, 8, 2);
    check("lost_clear", lostOut, 0);
    scan_frame(16'h1235, 8, 2);
    check("relock", lockedOut, 1);
    drive(4'hF, 8'hFF, 80);
    check("lost_after_lock", lostOut, 1);
    check("unlock_after_lost", lockedOut, 0);
    check_outs("outs_after_lost", 16'h1235);

    // Reset mid-frame after three accepted digits
    drive(4'b1110, {1'b1, ~seg_code(4'd6)}, 8);
    drive(4'b1101, {1'b1, ~seg_code(4'd7)}, 8);
    drive(4'b1011, {1'b1, ~seg_code(4'd8)}, 8);
    drive(4'b0111, {1'b1, ~seg_code(4'd9)}, 3);
    #1 reset = 1'b1;
    model_reset();
    #1;
    check_outs("midreset_outs", 16'h0000);
    check("midreset_flags", {updatePulse, lockedOut, errorOut, lostOut}, 4'b0000);
    u0 = upd_seen;
    drive(4'hF, 8'hFF, 3);
    reset = 1'b0;
    base  = cyc;
    drive(4'hF, 8'hFF, 4);
    scan_frame(16'h9876, 8, 2);
    check("single_frame_no_pub", upd_seen, u0);
    check_outs("single_frame_outs", 16'h0000);
    scan_frame(16'h9876, 8, 2);
    check_outs("outs_9876", 16'h9876);

    // Randomized scanning with repeats, glitches, bad codes and stalls
    cur = 16'h9876;
    for (int f = 0; f < 120; f++) begin
      if ($urandom_range(0, 99) < 35)
        for (int i = 0; i < 4; i++) cur[i*4 +: 4] = 4'($urandom_range(0, 9));
      for (int i = 0; i < 4; i++) begin
        c = ~(4'b0001 << i);
        s = {1'($urandom_range(0, 1)), ~seg_code(cur[i*4 +: 4])};
        r = $urandom_range(0, 99);
        if (r < 3)      s[6:0] = 7'($urandom);
        else if (r < 5) c = 4'($urandom);
        drive(c, s, $urandom_range(3, 10));
        drive(4'hF, 8'hFF, $urandom_range(0, 3));
      end
      if ($urandom_range(0, 99) < 2) drive(4'hF, 8'hFF, 70);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/display_scan_decoder.md
Name: display_scan_decoder

Overview:
- Receive end of the multiplexed 4-digit seven-segment display interface. Digit-select and segment lines come in; four BCD digits go out.
- Samples the scanned lines on a fast system clock, decodes each digit's segment pattern, assembles complete frames, and publishes digits only after repeated identical frames.
- Used as the loopback checker and capture front-end for the decimal-counter display path.

Parameters:
- SYNC_STAGES, 2: synchronizer depth on controlIn/segIn; minimum 2.
- SETTLE_CYCLES, 4: consecutive identical synced cycles needed before a digit sample is accepted; minimum 1.
- MATCH_FRAMES, 2: consecutive identical complete frames needed before publishing; minimum 1.
- TIMEOUT_CYCLES, 65535: cycles without a completed frame before lostOut is raised.

Ports:
- clock  in  1  system clock; must be at least 4x faster than the scan rate.
- reset  in  1  asynchronous, active-high.
- controlIn  in  4  digit select, active-low one-hot. Bit0 = ones, bit1 = tens, bit2 = hundreds, bit3 = thousands. Asynchronous to clock.
- segIn  in  8  segments, active-low. Bit0..6 = a..g, bit7 = dp (ignored). Asynchronous to clock.
- onesOut, tensOut, hundredsOut, thousandsOut  out  4 each  published BCD digits.
- updatePulse  out  1  one-cycle pulse when the published digits are (re)loaded.
- lockedOut  out  1  level; published digits match the live display.
- errorOut  out  1  one-cycle pulse on an invalid pattern or a multi-select.
- lostOut  out  1  level; no frame completed within TIMEOUT_CYCLES.

Behaviour:
- Reset (async, immediate, including mid-frame):
  - all digit outputs 0; updatePulse, lockedOut, errorOut, lostOut all 0.
  - synchronizer flops set to all-ones (idle bus).
  - seenMask, matchCnt, settleCnt, timeoutCnt cleared; state SCAN.
- Synchronizer: controlIn and segIn each pass through SYNC_STAGES flops. All logic below uses the synced values.
- Settle filter:
  - settleCnt resets to 0 whenever synced {controlIn,segIn} differs from the previous cycle; otherwise increments, saturating.
  - Exactly one sample per dwell is accepted, on the cycle the bus has been stable for SETTLE_CYCLES cycles.
  - Latency from pin change to acceptance: SYNC_STAGES + SETTLE_CYCLES cycles.
- Select decode at acceptance:
  - exactly one bit low: digit index = position of the low bit.
  - all high: blanking gap; ignored, no error.
  - two or more low: errorOut pulse, frame aborted (seenMask cleared, matchCnt cleared, lockedOut cleared).
- Segment decode (active-high gfedcba after inversion): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
  - Any other code, including blank 00, is invalid: errorOut pulse and frame aborted.
  - dp is ignored.
- Valid sample: frameBuf[idx] <= value; seenMask[idx] <= 1. A repeated digit before the frame completes overwrites its slot; no error.
- FSM:
  - SCAN: accumulate samples. When seenMask becomes 4'b1111, go to EVAL.
  - EVAL (one cycle), then clear seenMask and return to SCAN:
    - If frameBuf equals lastFrame: matchCnt++, saturating at MATCH_FRAMES.
    - Otherwise: lastFrame <= frameBuf, matchCnt <= 1, lockedOut <= 0.
    - If the new matchCnt equals MATCH_FRAMES and (lockedOut is 0 or lastFrame differs from the outputs): load the outputs and pulse updatePulse in the same cycle, then set lockedOut <= 1.
    - If already locked with the same value: no pulse.
  - A sample arriving during EVAL is held in SCAN's next cycle. Acceptance cannot occur on consecutive cycles when SETTLE_CYCLES >= 2. When SETTLE_CYCLES = 1, the sample is buffered for one cycle.
- updatePulse timing: asserted in the cycle after the fourth digit of the qualifying frame is accepted.
- Timeout:
  - timeoutCnt increments every cycle and clears in EVAL.
  - On reaching TIMEOUT_CYCLES: lostOut <= 1 and lockedOut <= 0; outputs hold; counter saturates.
  - lostOut clears in the next EVAL.
- Outputs only change on updatePulse; they hold through errors, timeouts and unlocks.
- Arithmetic: counter widths are $clog2(param + 1). All comparisons are unsigned. No wrap on any counter.

Decomposition:
- Shared package display_pkg:
  - digit-index constants ONES/TENS/HUNDREDS/THOUSANDS = 0..3.
  - SEG_0..SEG_9 active-high 7-bit codes.
  - BLANK_SELECT = 4'b1111.
  - FSM state enum {SCAN, EVAL}.
- One combinational sub-module, seg7_to_bcd: 7-bit active-high segments in; 4-bit value and valid out. Reused by any future display checker.
- Synchronizer, settle filter and FSM stay in the top level.

Test Plan:
- Scan 1234 repeatedly (ones=4 first), 8-cycle dwell, 2-cycle blank gaps, SETTLE=4, MATCH=2 -> first updatePulse at end of frame 2; outputs thousands=1 hundreds=2 tens=3 ones=4; lockedOut=1; no pulse on frame 3.
- Locked on 1234, display switches to 1235 -> lockedOut drops at the first 1235 EVAL; outputs hold 1234; updatePulse with ones=5 one frame later.
- During tens dwell, segIn code 0x49 (inverted 0x36, invalid) -> single errorOut pulse; frame aborted; next two clean frames republish.
- controlIn=4'b1100 stable for 4+ cycles -> errorOut pulse; blank controlIn=4'b1111 for 100 cycles -> no error.
- Stop scanning after lock, TIMEOUT=64 -> lostOut=1 and lockedOut=0 at cycle 64; outputs unchanged; resume scan -> lostOut=0 at next EVAL.
- Assert reset mid-frame after 3 digits accepted -> all outputs 0 immediately; subsequent single frame does not publish (MATCH=2).
